// File: rtl/phy_link_monitor.sv
// rtl/phy_link_monitor.sv - MDIO PHY link monitor: BMCR init write, then periodic double BMSR poll.
module phy_link_monitor #(
  parameter logic [4:0]  PHY_ADDR    = 5'd0,
  parameter logic [15:0] INIT_BMCR   = 16'h1140,
  parameter int unsigned POLL_CYCLES = 125000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [4:0]  mdio_phy_addr,
  output logic [4:0]  mdio_reg_addr,
  output logic [15:0] mdio_wdata,
  output logic [1:0]  mdio_op,
  output logic        mdio_start,
  input  logic [15:0] mdio_rdata,
  input  logic        mdio_ready,
  input  logic        mdio_error,
  output logic        link_up,
  output logic        an_done,
  output logic        link_change,
  output logic        init_done,
  output logic [7:0]  err_count
);

  localparam logic [1:0]  OP_WR    = 2'b01;
  localparam logic [1:0]  OP_RD    = 2'b10;
  localparam logic [4:0]  REG_BMCR = 5'd0;
  localparam logic [4:0]  REG_BMSR = 5'd1;
  localparam logic [23:0] GAP_LAST = 24'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, INIT_REQ, INIT_WAIT, GAP, RD1_REQ, RD1_WAIT, RD2_REQ, RD2_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] gap_cnt_q, gap_cnt_d;
  logic        arm_q;
  logic        first_q;
  logic        start_q, start_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  reg_q, reg_d;
  logic [4:0]  phy_q, phy_d;
  logic [15:0] wdata_q, wdata_d;
  logic        link_up_q, link_up_d;
  logic        an_done_q, an_done_d;
  logic        link_change_q, link_change_d;
  logic        init_done_q, init_done_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        complete;
  logic        rdata_unused;

  assign rdata_unused = ^{mdio_rdata[15:6], mdio_rdata[4:3], mdio_rdata[1:0]};

  // The first WAIT cycle still shows the controller's pre-start ready level.
  assign complete = mdio_ready && !first_q;

  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    op_d          = op_q;
    reg_d         = reg_q;
    phy_d         = phy_q;
    wdata_d       = wdata_q;
    link_up_d     = link_up_q;
    an_done_d     = an_done_q;
    init_done_d   = init_done_q;
    err_count_d   = err_count_q;

    case (state_q)
      IDLE: begin
        if (arm_q && enable && mdio_ready)
          state_d = init_done_q ? RD1_REQ : INIT_REQ;
      end
      INIT_REQ: state_d = INIT_WAIT;
      RD1_REQ:  state_d = RD1_WAIT;
      RD2_REQ:  state_d = RD2_WAIT;
      INIT_WAIT: begin
        if (complete) begin
          if (mdio_error) begin
            state_d = enable ? GAP : IDLE;
          end else begin
            init_done_d = 1'b1;
            state_d     = enable ? RD1_REQ : IDLE;
          end
        end
      end
      RD1_WAIT: begin
        if (complete)
          state_d = enable ? RD2_REQ : IDLE;
      end
      RD2_WAIT: begin
        if (complete) begin
          if (!mdio_error) begin
            link_up_d = mdio_rdata[2];
            an_done_d = mdio_rdata[5];
          end
          state_d = enable ? GAP : IDLE;
        end
      end
      GAP: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (gap_cnt_q == GAP_LAST) begin
          if (mdio_ready)
            state_d = init_done_q ? RD1_REQ : INIT_REQ;
        end else begin
          gap_cnt_d = gap_cnt_q + 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete && mdio_error && err_count_q != 8'hFF &&
        (state_q == INIT_WAIT || state_q == RD1_WAIT || state_q == RD2_WAIT))
      err_count_d = err_count_q + 8'd1;

    if (state_d == GAP && state_q != GAP)
      gap_cnt_d = 24'd0;

    if (state_d == IDLE && state_q != IDLE) begin
      link_up_d = 1'b0;
      an_done_d = 1'b0;
    end

    // Transaction fields load only when a request is issued, holding through WAIT.
    start_d = (state_d == INIT_REQ) || (state_d == RD1_REQ) || (state_d == RD2_REQ);
    if (state_d == INIT_REQ) begin
      op_d    = OP_WR;
      reg_d   = REG_BMCR;
      phy_d   = PHY_ADDR;
      wdata_d = INIT_BMCR;
    end else if (state_d == RD1_REQ || state_d == RD2_REQ) begin
      op_d    = OP_RD;
      reg_d   = REG_BMSR;
      phy_d   = PHY_ADDR;
      wdata_d = 16'h0000;
    end

    link_change_d = link_up_d ^ link_up_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gap_cnt_q     <= 24'd0;
      arm_q         <= 1'b0;
      first_q       <= 1'b0;
      start_q       <= 1'b0;
      op_q          <= 2'b00;
      reg_q         <= 5'd0;
      phy_q         <= 5'd0;
      wdata_q       <= 16'h0000;
      link_up_q     <= 1'b0;
      an_done_q     <= 1'b0;
      link_change_q <= 1'b0;
      init_done_q   <= 1'b0;
      err_count_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      arm_q         <= 1'b1;
      first_q       <= start_q;
      start_q       <= start_d;
      op_q          <= op_d;
      reg_q         <= reg_d;
      phy_q         <= phy_d;
      wdata_q       <= wdata_d;
      link_up_q     <= link_up_d;
      an_done_q     <= an_done_d;
      link_change_q <= link_change_d;
      init_done_q   <= init_done_d;
      err_count_q   <= err_count_d;
    end
  end

  assign mdio_start    = start_q;
  assign mdio_op       = op_q;
  assign mdio_reg_addr = reg_q;
  assign mdio_phy_addr = phy_q;
  assign mdio_wdata    = wdata_q;
  assign link_up       = link_up_q;
  assign an_done       = an_done_q;
  assign link_change   = link_change_q;
  assign init_done     = init_done_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_phy_link_monitor.sv
// tb/tb_phy_link_monitor.sv - directed bench for phy_link_monitor with a behavioural MDIO controller.
module tb_phy_link_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [4:0]  mdio_phy_addr, mdio_reg_addr;
  logic [15:0] mdio_wdata;
  logic [1:0]  mdio_op;
  logic        mdio_start;
  logic [15:0] mdio_rdata;
  logic        mdio_ready;
  logic        mdio_error;
  logic        link_up, an_done, link_change, init_done;
  logic [7:0]  err_count;

  phy_link_monitor #(.PHY_ADDR(5'd7), .INIT_BMCR(16'h1140), .POLL_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .mdio_phy_addr(mdio_phy_addr), .mdio_reg_addr(mdio_reg_addr),
    .mdio_wdata(mdio_wdata), .mdio_op(mdio_op), .mdio_start(mdio_start),
    .mdio_rdata(mdio_rdata), .mdio_ready(mdio_ready), .mdio_error(mdio_error),
    .link_up(link_up), .an_done(an_done), .link_change(link_change),
    .init_done(init_done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [1:0]  tx_op[$];
  logic [4:0]  tx_phy[$];
  logic [4:0]  tx_reg[$];
  logic [15:0] tx_wdata[$];
  int          tx_start_neg[$];
  int          tx_done_neg[$];
  logic [16:0] resp_q[$];
  logic        default_err;
  logic        abort;
  int          negcnt = 0;
  int          viol_start = 0;
  int          viol_hold = 0;
  int          pulses = 0;
  int          wide_pulses = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Controller: drops ready on start, answers three cycles later, error valid with ready.
  initial begin
    logic [1:0]  c_op;
    logic [4:0]  c_phy, c_reg;
    logic [15:0] c_wd;
    logic [16:0] r;
    mdio_ready = 1'b1;
    mdio_rdata = 16'h0;
    mdio_error = 1'b0;
    forever begin
      @(negedge clk); negcnt++;
      if (mdio_start) begin
        if (!mdio_ready) viol_start++;
        c_op = mdio_op; c_phy = mdio_phy_addr; c_reg = mdio_reg_addr; c_wd = mdio_wdata;
        tx_op.push_back(c_op); tx_phy.push_back(c_phy); tx_reg.push_back(c_reg);
        tx_wdata.push_back(c_wd); tx_start_neg.push_back(negcnt);
        abort = 1'b0;
        mdio_ready = 1'b0;
        mdio_error = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk); negcnt++;
          if (mdio_start) viol_start++;
          if (rst_n && !abort &&
              (mdio_op !== c_op || mdio_phy_addr !== c_phy ||
               mdio_reg_addr !== c_reg || mdio_wdata !== c_wd))
            viol_hold++;
        end
        r = (resp_q.size() > 0) ? resp_q.pop_front() : {default_err, 16'h0000};
        mdio_rdata = r[15:0];
        mdio_error = r[16];
        mdio_ready = 1'b1;
        tx_done_neg.push_back(negcnt);
      end
    end
  end

  initial begin
    logic prev_lc = 1'b0;
    forever begin
      @(negedge clk);
      if (link_change) pulses++;
      if (link_change && prev_lc) wide_pulses++;
      prev_lc = link_change;
    end
  end

  task automatic wait_tx(input int n, input string tag);
    for (int i = 0; i < 10000 && tx_op.size() < n; i++) @(negedge clk);
    check_eq(tag, 32'(tx_op.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int n, input string tag);
    for (int i = 0; i < 10000 && tx_done_neg.size() < n; i++) @(negedge clk);
    check_eq(tag, 32'(tx_done_neg.size() >= n), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  function automatic int gap_after(input int i);
    return tx_start_neg[i+1] - tx_done_neg[i] - 1;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_start"},  32'(mdio_start),    32'd0);
    check_eq({pfx, "_op"},     32'(mdio_op),       32'd0);
    check_eq({pfx, "_phy"},    32'(mdio_phy_addr), 32'd0);
    check_eq({pfx, "_reg"},    32'(mdio_reg_addr), 32'd0);
    check_eq({pfx, "_wdata"},  32'(mdio_wdata),    32'd0);
    check_eq({pfx, "_link"},   32'(link_up),       32'd0);
    check_eq({pfx, "_an"},     32'(an_done),       32'd0);
    check_eq({pfx, "_lchg"},   32'(link_change),   32'd0);
    check_eq({pfx, "_init"},   32'(init_done),     32'd0);
    check_eq({pfx, "_errcnt"}, 32'(err_count),     32'd0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; enable = 1'b0; abort = 1'b0; default_err = 1'b0;
    // init, then polls: RD1 data is discarded, RD2 bit2 = link, bit5 = an.
    resp_q = '{17'h0_0000,
               17'h0_796D, 17'h0_7949,
               17'h0_0000, 17'h0_796D,
               17'h0_0000, 17'h0_796D,
               17'h0_0000, 17'h0_7969,
               17'h0_0000, 17'h0_796D,
               17'h0_0000, 17'h1_0000,
               17'h0_0000, 17'h0_0000, 17'h0_0000};
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    enable = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); check_eq("start_edge1", 32'(mdio_start), 32'd0);
    @(negedge clk); check_eq("start_edge2", 32'(mdio_start), 32'd1);

    wait_done(1, "init_done_to");
    check_eq("init_op",    32'(tx_op[0]),    32'h1);
    check_eq("init_phy",   32'(tx_phy[0]),   32'd7);
    check_eq("init_reg",   32'(tx_reg[0]),   32'd0);
    check_eq("init_wdata", 32'(tx_wdata[0]), 32'h1140);
    check_eq("init_done",  32'(init_done),   32'd1);

    wait_done(3, "p1_to");
    check_eq("rd1_op",  32'(tx_op[1]),  32'h2);
    check_eq("rd1_reg", 32'(tx_reg[1]), 32'd1);
    check_eq("rd1_phy", 32'(tx_phy[1]), 32'd7);
    check_eq("rd2_op",  32'(tx_op[2]),  32'h2);
    check_eq("rd2_reg", 32'(tx_reg[2]), 32'd1);
    check_eq("p1_link", 32'(link_up), 32'd0);
    check_eq("p1_an",   32'(an_done), 32'd0);
    check_eq("p1_pulses", 32'(pulses), 32'd0);

    wait_tx(4, "p2_start_to");
    check_eq("poll_gap", 32'(gap_after(2)), 32'd10);

    wait_done(5, "p2_to");
    check_eq("p2_link", 32'(link_up), 32'd1);
    check_eq("p2_an",   32'(an_done), 32'd1);
    check_eq("p2_pulses", 32'(pulses), 32'd1);

    wait_done(7, "p3_to");
    check_eq("p3_link", 32'(link_up), 32'd1);
    check_eq("p3_pulses", 32'(pulses), 32'd1);

    wait_done(9, "p4_to");
    check_eq("p4_link", 32'(link_up), 32'd0);
    check_eq("p4_an",   32'(an_done), 32'd1);
    check_eq("p4_pulses", 32'(pulses), 32'd2);

    wait_done(11, "p5_to");
    check_eq("p5_link", 32'(link_up), 32'd1);
    check_eq("p5_pulses", 32'(pulses), 32'd3);

    wait_done(13, "p6_to");
    check_eq("p6_link_hold", 32'(link_up),   32'd1);
    check_eq("p6_an_hold",   32'(an_done),   32'd1);
    check_eq("p6_errcnt",    32'(err_count), 32'd1);

    wait_tx(14, "p7_start_to");
    @(negedge clk); enable = 1'b0;
    repeat (25) @(negedge clk);
    check_eq("dis_tx_count",   32'(tx_op.size()),       32'd14);
    check_eq("dis_rd1_done",   32'(tx_done_neg.size()), 32'd14);
    check_eq("dis_link",       32'(link_up),   32'd0);
    check_eq("dis_an",         32'(an_done),   32'd0);
    check_eq("dis_pulses",     32'(pulses),    32'd4);
    check_eq("dis_init_hold",  32'(init_done), 32'd1);
    check_eq("dis_errcnt",     32'(err_count), 32'd1);

    enable = 1'b1;
    wait_tx(15, "reen_to");
    check_eq("reen_op_read", 32'(tx_op[14]), 32'h2);
    wait_tx(16, "rst_rd2_to");
    @(negedge clk);
    #2 abort = 1'b1; rst_n = 1'b0;
    #1 check_reset_outputs("midrst");

    default_err = 1'b1;
    for (int i = 0; i < 20 && !mdio_ready; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    base = tx_op.size();
    rst_n = 1'b1;

    wait_done(base + 1, "ierr_to");
    check_eq("ierr_init", 32'(init_done), 32'd0);
    check_eq("ierr_cnt",  32'(err_count), 32'd1);
    check_eq("ierr_op",   32'(tx_op[base]),  32'h1);
    check_eq("ierr_reg",  32'(tx_reg[base]), 32'd0);
    wait_tx(base + 2, "iretry_to");
    check_eq("iretry_op",  32'(tx_op[base+1]), 32'h1);
    check_eq("iretry_gap", 32'(gap_after(base)), 32'd10);

    wait_done(base + 300, "sat_to");
    default_err = 1'b0;
    check_eq("sat_cnt",  32'(err_count), 32'hFF);
    check_eq("sat_init", 32'(init_done), 32'd0);
    for (int i = 0; i < 100 && !init_done; i++) @(negedge clk);
    check_eq("recov_init", 32'(init_done), 32'd1);
    check_eq("recov_cnt",  32'(err_count), 32'hFF);

    check_eq("start_while_busy", 32'(viol_start),  32'd0);
    check_eq("field_hold",       32'(viol_hold),   32'd0);
    check_eq("pulse_width",      32'(wide_pulses), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
